// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter that funnels CPUS x {I,D} requestors onto one RAM port.
// Optional per-requestor completion counters are enabled with ARB_STATS_EN.
module ram_arbiter_rr #(
    parameter int CPUS  = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DPRIO = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [2*CPUS-1:0]      req_ren,
    input  logic [2*CPUS-1:0]      req_wen,
    input  logic [2*CPUS*AW-1:0]   req_addr,
    input  logic [2*CPUS*DW-1:0]   req_store,
    output logic [2*CPUS-1:0]      req_wait,
    output logic [DW-1:0]          req_load,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [AW-1:0]          ramaddr,
    output logic [DW-1:0]          ramstore,
    input  logic [DW-1:0]          ramload,
    input  logic [1:0]             ramstate
`ifdef ARB_STATS_EN
    ,
    output logic [2*CPUS*16-1:0]   grant_cnt,
    input  logic                   stats_clr
`endif
);
    localparam int NREQ = 2 * CPUS;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state_next;
    logic [IW-1:0]   r_gnt, w_gnt_next;
    logic [IW-1:0]   r_rr_ptr, w_rr_next;
    logic [IW-1:0]   w_sel, w_idx;
    logic            w_found;
    logic [NREQ-1:0] w_active, w_odd_mask, w_cand;
    logic            w_g_active, w_done;
    logic [AW-1:0]   w_addr_arr  [NREQ];
    logic [DW-1:0]   w_store_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign w_store_arr[gi] = req_store[gi*DW +: DW];
            assign w_odd_mask[gi]  = (gi % 2) == 1;
        end
    endgenerate

    assign w_active   = req_ren | req_wen;
    assign w_g_active = req_ren[r_gnt] | req_wen[r_gnt];
    assign w_done     = (r_state == S_GRANT) && w_g_active && (ramstate == RAM_ACCESS);

    // With data priority, the odd (D-channel) class is searched alone whenever it has work.
    always_comb begin
        w_cand = w_active;
        if (DPRIO != 0 && |(w_active & w_odd_mask))
            w_cand = w_active & w_odd_mask;
    end

    always_comb begin
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_gnt    <= w_gnt_next;
            r_rr_ptr <= w_rr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_rr_next    = r_rr_ptr;
        req_wait     = '1;
        req_load     = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_GRANT;
                    w_gnt_next   = w_sel;
                end
            end
            S_GRANT: begin
                ramaddr  = w_addr_arr[r_gnt];
                ramstore = w_store_arr[r_gnt];
                ramWEN   = req_wen[r_gnt];
                ramREN   = req_ren[r_gnt] & ~req_wen[r_gnt];
                if (!w_g_active) begin
                    w_state_next = S_IDLE;
                end else if (w_done) begin
                    req_wait[r_gnt] = 1'b0;
                    req_load        = ramload;
                    w_state_next    = S_IDLE;
                    w_rr_next       = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)
                    r_cnt <= '0;
                else if (stats_clr)
                    r_cnt <= '0;
                else if (w_done && r_gnt == IW'(gi) && r_cnt != 16'hFFFF)
                    r_cnt <= r_cnt + 16'd1;
            end
            assign grant_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed bench for ram_arbiter_rr: one round-robin instance and one data-priority instance.
module tb_ram_arbiter_rr;
    logic         CLK;
    logic         RST;
    logic [3:0]   req_ren, req_wen;
    logic [127:0] req_addr, req_store;
    logic [31:0]  ramload;
    logic [1:0]   ramstate;

    logic [3:0]   d0_wait, d1_wait;
    logic [31:0]  d0_load, d1_load, d0_addr, d1_addr, d0_store, d1_store;
    logic         d0_ren, d1_ren, d0_wen, d1_wen;
`ifdef ARB_STATS_EN
    logic [63:0]  d0_cnt, d1_cnt;
    logic         stats_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ram_arbiter_rr #(.CPUS(2), .AW(32), .DW(32), .DPRIO(0)) dut0 (
        .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store), .req_wait(d0_wait), .req_load(d0_load),
        .ramREN(d0_ren), .ramWEN(d0_wen), .ramaddr(d0_addr), .ramstore(d0_store),
        .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
        , .grant_cnt(d0_cnt), .stats_clr(stats_clr)
`endif
    );

    ram_arbiter_rr #(.CPUS(2), .AW(32), .DW(32), .DPRIO(1)) dut1 (
        .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store), .req_wait(d1_wait), .req_load(d1_load),
        .ramREN(d1_ren), .ramWEN(d1_wen), .ramaddr(d1_addr), .ramstore(d1_store),
        .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
        , .grant_cnt(d1_cnt), .stats_clr(stats_clr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic init_bus();
        req_ren  = '0;
        req_wen  = '0;
        ramload  = '0;
        ramstate = 2'd0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = 32'h1000 + i;
            req_store[i*32 +: 32] = 32'hA000 + i;
        end
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    // Leaves the bench 1 time unit after a rising edge with both DUTs in IDLE.
    task automatic do_reset();
        RST = 1'b1;
        init_bus();
        #2;
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [1:0] busy_st[5] = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd1};

    initial begin
        RST = 1'b1;
        init_bus();
        #2;
        check("rst_ren",   {31'd0, d0_ren}, 32'd0);
        check("rst_wen",   {31'd0, d0_wen}, 32'd0);
        check("rst_addr",  d0_addr, 32'd0);
        check("rst_store", d0_store, 32'd0);
        check("rst_wait",  {28'd0, d0_wait}, 32'hF);
        check("rst_load",  d0_load, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Single read from requestor 1, completed in the first GRANT cycle.
        do_reset();
        req_ren = 4'b0010;
        req_addr[32 +: 32] = 32'h100;
        #1;
        check("rd_idle_wait", {28'd0, d0_wait}, 32'hF);
        check("rd_idle_ren",  {31'd0, d0_ren}, 32'd0);
        tick();
        ramstate = 2'd2;
        ramload  = 32'hDEADBEEF;
        #1;
        check("rd_ren",  {31'd0, d0_ren}, 32'd1);
        check("rd_addr", d0_addr, 32'h100);
        check("rd_wait", {28'd0, d0_wait}, 32'hD);
        check("rd_load", d0_load, 32'hDEADBEEF);
        tick();
        req_ren  = 4'b1111;
        ramstate = 2'd0;
        #1;
        check("rd_after_wait", {28'd0, d0_wait}, 32'hF);
        check("rd_after_load", d0_load, 32'd0);
        tick();
        #1;
        check("rd_rrptr2_addr", d0_addr, 32'h1002);

        // Round-robin from reset with all requestors active.
        do_reset();
        req_ren  = 4'b1111;
        ramstate = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_addr%0d", i), d0_addr, 32'h1000 + rr_exp[i]);
            check($sformatf("rr_wait%0d", i), {28'd0, d0_wait}, {28'd0, ~(4'b0001 << rr_exp[i])});
            tick();
            check($sformatf("rr_idle%0d", i), {28'd0, d0_wait}, 32'hF);
        end

        // Data-first instance serves odd indices before even ones.
        do_reset();
        req_ren  = 4'b1111;
        ramstate = 2'd2;
        tick();
        check("dp_first_d1", d1_addr, 32'h1001);
        check("dp_first_d0", d0_addr, 32'h1000);
        tick();
        tick();
        check("dp_second_d1", d1_addr, 32'h1003);
        check("dp_second_d0", d0_addr, 32'h1001);
        tick();
        req_ren = 4'b0101;
        tick();
        check("dp_third_d1", d1_addr, 32'h1000);
        tick();
        tick();
        check("dp_fourth_d1", d1_addr, 32'h1002);

        // Write from requestor 3 held across non-ACCESS cycles.
        do_reset();
        req_wen = 4'b1000;
        req_addr[96 +: 32]  = 32'h2000;
        req_store[96 +: 32] = 32'h12345678;
        ramstate = 2'd1;
        ramload  = 32'h55AA;
        tick();
        req_ren = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            ramstate = busy_st[i];
            #1;
            check($sformatf("bz_wen%0d", i),   {31'd0, d0_wen}, 32'd1);
            check($sformatf("bz_ren%0d", i),   {31'd0, d0_ren}, 32'd0);
            check($sformatf("bz_addr%0d", i),  d0_addr, 32'h2000);
            check($sformatf("bz_store%0d", i), d0_store, 32'h12345678);
            check($sformatf("bz_wait%0d", i),  {28'd0, d0_wait}, 32'hF);
            tick();
        end
        ramstate = 2'd2;
        #1;
        check("bz_done_store", d0_store, 32'h12345678);
        check("bz_done_wait",  {28'd0, d0_wait}, 32'h7);
        check("bz_done_load",  d0_load, 32'h55AA);
        tick();
        req_wen = 4'b0000;
        check("bz_idle_wait", {28'd0, d0_wait}, 32'hF);
        tick();
        check("bz_wrap_addr", d0_addr, 32'h1000);

        // Abort: grantee withdraws during BUSY, pointer stays put.
        do_reset();
        req_ren  = 4'b0100;
        ramstate = 2'd1;
        tick();
        check("ab_ren",  {31'd0, d0_ren}, 32'd1);
        check("ab_addr", d0_addr, 32'h1002);
        tick();
        req_ren = 4'b0000;
        #1;
        check("ab_drop_ren",  {31'd0, d0_ren}, 32'd0);
        check("ab_drop_wait", {28'd0, d0_wait}, 32'hF);
        tick();
        req_ren = 4'b1111;
        #1;
        check("ab_idle_wait", {28'd0, d0_wait}, 32'hF);
        tick();
        check("ab_next_addr", d0_addr, 32'h1000);
        check("ab_next_ren",  {31'd0, d0_ren}, 32'd1);

        // Asynchronous reset in the middle of a grant.
        #1;
        RST = 1'b1;
        #1;
        check("ar_ren",  {31'd0, d0_ren}, 32'd0);
        check("ar_wait", {28'd0, d0_wait}, 32'hF);
        check("ar_addr", d0_addr, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

`ifdef ARB_STATS_EN
        // Completion counters: three completions, then a clear colliding with a fourth.
        do_reset();
        req_ren  = 4'b0100;
        ramstate = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        check("st_cnt3_d0", {16'd0, d0_cnt[32 +: 16]}, 32'd3);
        check("st_cnt3_d1", {16'd0, d1_cnt[32 +: 16]}, 32'd3);
        check("st_cnt_other", {16'd0, d0_cnt[0 +: 16]}, 32'd0);
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("st_clr_d0", {16'd0, d0_cnt[32 +: 16]}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
